// File: rtl/outputc_vc_credit_pkg.sv
// Shared NoC constants: flit type field, enable levels, error-flag bit positions.
package outputc_vc_credit_pkg;

  localparam int unsigned TYPE_MSB = 31;
  localparam int unsigned TYPE_LSB = 30;

  typedef enum logic [1:0] {
    TYPE_NONE = 2'd0,
    TYPE_HEAD = 2'd1,
    TYPE_BODY = 2'd2,
    TYPE_TAIL = 2'd3
  } flit_type_e;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int unsigned ERR_OVF  = 0;
  localparam int unsigned ERR_UNF  = 1;
  localparam int unsigned ERR_IVCH = 2;
  localparam int unsigned ERR_W    = 3;

endpackage

// File: rtl/outputc_vc_credit_if.sv
// Crossbar-side flit input, link-side flit output and allocator-side credit/lock bundle.
interface outputc_vc_credit_if
  import outputc_vc_credit_pkg::*;
#(
  parameter int unsigned DATAW = 32,
  parameter int unsigned NVCH  = 4
);
  localparam int unsigned VCW = $clog2(NVCH);

  logic [DATAW-1:0] idata;
  logic             ivalid;
  logic [VCW-1:0]   ivch;
  logic [DATAW-1:0] odata;
  logic             ovalid;
  logic [VCW-1:0]   ovch;
  logic [NVCH-1:0]  iack;
  logic [NVCH-1:0]  ordy;
  logic [NVCH-1:0]  ilck;
  logic [NVCH-1:0]  olck;
  logic [ERR_W-1:0] oerr;

  // Environment side: drives flits, credits and downstream locks.
  modport master (
    output idata, ivalid, ivch, iack, ilck,
    input  odata, ovalid, ovch, ordy, olck, oerr
  );

  // Output-channel stage side.
  modport slave (
    input  idata, ivalid, ivch, iack, ilck,
    output odata, ovalid, ovch, ordy, olck, oerr
  );
endinterface

// File: rtl/outputc_vc_credit_ctr.sv
// Per-VC downstream credit counter with saturating update and ready generation.
module outputc_vc_credit_ctr #(
  parameter int unsigned FIFOD    = 8,
  parameter int unsigned PKTLEN   = 4,
  parameter int unsigned RDY_MODE = 0,
  parameter int unsigned CW       = $clog2(FIFOD + 1)
) (
  input  logic clk,
  input  logic rst_,
  input  logic send_i,
  input  logic ack_i,
  output logic rdy_c_o,
  output logic ovf_c_o,
  output logic unf_c_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Occupancy update: simultaneous send and credit return cancel out; never wraps.
  always_comb begin
    cnt_d   = cnt_q;
    ovf_c_o = 1'b0;
    unf_c_o = 1'b0;
    if (send_i && !ack_i) begin
      if (cnt_q == CW'(FIFOD)) ovf_c_o = 1'b1;
      else                     cnt_d   = cnt_q + CW'(1);
    end else if (!send_i && ack_i) begin
      if (cnt_q == CW'(0)) unf_c_o = 1'b1;
      else                 cnt_d   = cnt_q - CW'(1);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Ready: room for a whole packet, or for a single flit.
  if (RDY_MODE == 0) begin : g_pkt_rdy
    logic [CW:0] space_c;
    assign space_c = (CW+1)'(FIFOD) - {1'b0, cnt_q};
    assign rdy_c_o = (space_c >= (CW+1)'(PKTLEN));
  end else begin : g_flit_rdy
    assign rdy_c_o = ({1'b0, cnt_q} < (CW+1)'(FIFOD));
  end

endmodule

// File: rtl/outputc_vc_credit.sv
// Router output-channel stage: link flit register, per-VC credits, locks and sticky errors.
module outputc_vc_credit
  import outputc_vc_credit_pkg::*;
#(
  parameter int          ROUTERID = 0,
  parameter int          PCHID    = 0,
  parameter int unsigned DATAW    = 32,
  parameter int unsigned NVCH     = 4,
  parameter int unsigned FIFOD    = 8,
  parameter int unsigned PKTLEN   = 4,
  parameter int unsigned RDY_MODE = 0
) (
  input  logic                clk,
  input  logic                rst_,
  outputc_vc_credit_if.slave  ch
);

  localparam int unsigned VCW = $clog2(NVCH);
  localparam int unsigned CW  = $clog2(FIFOD + 1);

  // Configuration sanity; the ids exist only for debug identification.
  if (NVCH < 2 || PKTLEN < 1 || PKTLEN > FIFOD || ROUTERID < 0 || PCHID < 0) begin : g_bad_cfg
    $error("outputc_vc_credit: illegal parameter set");
  end

  logic [NVCH-1:0]  send_c, ovf_c, unf_c, rdy_c;
  logic             ivch_ok_c, illegal_c, any_send_c;
  logic [DATAW-1:0] odata_q, odata_d;
  logic             ovalid_q, ovalid_d;
  logic [VCW-1:0]   ovch_q, ovch_d;
  logic [NVCH-1:0]  olck_q, olck_d;
  logic [ERR_W-1:0] oerr_q, oerr_d;

  // Decode the incoming flit into a one-hot legal send per VC.
  always_comb begin
    ivch_ok_c  = (32'(ch.ivch) < NVCH);
    illegal_c  = ch.ivalid && !ivch_ok_c;
    for (int v = 0; v < NVCH; v++) begin
      send_c[v] = ch.ivalid && ivch_ok_c && (ch.ivch == VCW'(v));
    end
    any_send_c = |send_c;
  end

  // Credit counters, one per VC.
  for (genvar v = 0; v < NVCH; v++) begin : g_vc
    outputc_vc_credit_ctr #(
      .FIFOD    (FIFOD),
      .PKTLEN   (PKTLEN),
      .RDY_MODE (RDY_MODE),
      .CW       (CW)
    ) u_ctr (
      .clk     (clk),
      .rst_    (rst_),
      .send_i  (send_c[v]),
      .ack_i   (ch.iack[v]),
      .rdy_c_o (rdy_c[v]),
      .ovf_c_o (ovf_c[v]),
      .unf_c_o (unf_c[v])
    );
  end

  // Next state of link register, locks and sticky error flags.
  always_comb begin
    odata_d  = odata_q;
    ovalid_d = ovalid_q;
    ovch_d   = ovch_q;
    olck_d   = olck_q;
    oerr_d   = oerr_q;

    if (any_send_c) begin
      odata_d  = ch.idata;
      ovch_d   = ch.ivch;
      ovalid_d = ENABLE;
    end else if (ovalid_q) begin
      odata_d  = '0;
      ovch_d   = '0;
      ovalid_d = DISABLE;
    end

    // A VC stays locked while a flit is in flight on it or downstream still holds it.
    for (int v = 0; v < NVCH; v++) begin
      if (send_c[v] || (ovalid_q && ovch_q == VCW'(v))) olck_d[v] = 1'b1;
      else if (olck_q[v] && !ch.ilck[v])              olck_d[v] = 1'b0;
    end

    oerr_d[ERR_OVF]  = oerr_q[ERR_OVF]  | (|ovf_c);
    oerr_d[ERR_UNF]  = oerr_q[ERR_UNF]  | (|unf_c);
    oerr_d[ERR_IVCH] = oerr_q[ERR_IVCH] | illegal_c;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      ovch_q   <= '0;
      olck_q   <= '0;
      oerr_q   <= '0;
    end else begin
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      ovch_q   <= ovch_d;
      olck_q   <= olck_d;
      oerr_q   <= oerr_d;
    end
  end

  assign ch.odata  = odata_q;
  assign ch.ovalid = ovalid_q;
  assign ch.ovch   = ovch_q;
  assign ch.olck   = olck_q;
  assign ch.oerr   = oerr_q;
  assign ch.ordy   = rdy_c;

endmodule

// File: tb/tb_outputc_vc_credit.sv
// Directed bench: packet-ready instance, flit-ready instance and a 3-VC instance.
module tb_outputc_vc_credit;

  logic clk = 1'b0;
  logic rst_ = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  outputc_vc_credit_if #(.DATAW(32), .NVCH(4)) if0 ();
  outputc_vc_credit_if #(.DATAW(32), .NVCH(4)) if1 ();
  outputc_vc_credit_if #(.DATAW(32), .NVCH(3)) if2 ();

  outputc_vc_credit #(.NVCH(4), .FIFOD(8), .PKTLEN(4), .RDY_MODE(0)) u0 (.clk(clk), .rst_(rst_), .ch(if0));
  outputc_vc_credit #(.NVCH(4), .FIFOD(8), .PKTLEN(4), .RDY_MODE(1)) u1 (.clk(clk), .rst_(rst_), .ch(if1));
  outputc_vc_credit #(.NVCH(3), .FIFOD(8), .PKTLEN(4), .RDY_MODE(0)) u2 (.clk(clk), .rst_(rst_), .ch(if2));

  task automatic idle();
    if0.idata = '0; if0.ivalid = 1'b0; if0.ivch = '0; if0.iack = '0; if0.ilck = '0;
    if1.idata = '0; if1.ivalid = 1'b0; if1.ivch = '0; if1.iack = '0; if1.ilck = '0;
    if2.idata = '0; if2.ivalid = 1'b0; if2.ivch = '0; if2.iack = '0; if2.ilck = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_ = 1'b0;
    #1;
    n_checks++; if (if0.ovalid !== 1'b0) begin n_fail++; $display("FAIL reset_ovalid: got %0h want 0", if0.ovalid); end
    n_checks++; if (if0.odata !== 32'h0) begin n_fail++; $display("FAIL reset_odata: got %0h want 0", if0.odata); end
    n_checks++; if (if0.ovch !== 2'd0) begin n_fail++; $display("FAIL reset_ovch: got %0h want 0", if0.ovch); end
    n_checks++; if (if0.olck !== 4'h0) begin n_fail++; $display("FAIL reset_olck: got %0h want 0", if0.olck); end
    n_checks++; if (if0.oerr !== 3'h0) begin n_fail++; $display("FAIL reset_oerr: got %0h want 0", if0.oerr); end
    n_checks++; if (if0.ordy !== 4'hF) begin n_fail++; $display("FAIL reset_ordy0: got %0h want f", if0.ordy); end
    n_checks++; if (if1.ordy !== 4'hF) begin n_fail++; $display("FAIL reset_ordy1: got %0h want f", if1.ordy); end
    n_checks++; if (if2.ordy !== 3'h7) begin n_fail++; $display("FAIL reset_ordy2: got %0h want 7", if2.ordy); end
    @(negedge clk);
    rst_ = 1'b1;
    tick();
  endtask

  task automatic test_fill_vc2();
    logic [31:0] exp_d;
    for (int i = 0; i < 5; i++) begin
      exp_d = 32'hA000_0000 + 32'(i);
      if0.ivalid = 1'b1; if0.ivch = 2'd2; if0.idata = exp_d;
      tick();
      n_checks++;
      if ({if0.ovalid, if0.ovch, if0.odata} !== {1'b1, 2'd2, exp_d}) begin
        n_fail++; $display("FAIL fill_out[%0d]: got v=%0h ch=%0h d=%0h want v=1 ch=2 d=%0h", i, if0.ovalid, if0.ovch, if0.odata, exp_d);
      end
      n_checks++;
      if (if0.ordy !== ((i < 4) ? 4'hF : 4'hB)) begin
        n_fail++; $display("FAIL fill_ordy[%0d]: got %0h want %0h", i, if0.ordy, (i < 4) ? 4'hF : 4'hB);
      end
    end
    n_checks++; if (u0.g_vc[2].u_ctr.cnt_q !== 4'd5) begin n_fail++; $display("FAIL fill_cnt2: got %0d want 5", u0.g_vc[2].u_ctr.cnt_q); end
    idle();
    tick();
    n_checks++; if ({if0.ovalid, if0.odata} !== 33'h0) begin n_fail++; $display("FAIL fill_drain_out: got v=%0h d=%0h want 0", if0.ovalid, if0.odata); end
    n_checks++; if (if0.olck !== 4'b0100) begin n_fail++; $display("FAIL fill_olck_hold: got %0h want 4", if0.olck); end
    n_checks++; if (if0.ordy !== 4'hB) begin n_fail++; $display("FAIL fill_ordy_idle: got %0h want b", if0.ordy); end
    if0.iack = 4'b0100;
    tick();
    n_checks++; if (if0.ordy !== 4'hF) begin n_fail++; $display("FAIL fill_ordy_ack: got %0h want f", if0.ordy); end
    n_checks++; if (if0.olck !== 4'b0000) begin n_fail++; $display("FAIL fill_olck_clr: got %0h want 0", if0.olck); end
    for (int i = 0; i < 4; i++) tick();
    idle();
    n_checks++; if (u0.g_vc[2].u_ctr.cnt_q !== 4'd0) begin n_fail++; $display("FAIL fill_cnt2_empty: got %0d want 0", u0.g_vc[2].u_ctr.cnt_q); end
    n_checks++; if (if0.oerr !== 3'h0) begin n_fail++; $display("FAIL fill_oerr: got %0h want 0", if0.oerr); end
  endtask

  task automatic test_send_ack_same();
    for (int i = 0; i < 3; i++) begin
      if0.ivalid = 1'b1; if0.ivch = 2'd1; if0.idata = 32'hB000_0000 + 32'(i);
      tick();
    end
    if0.ivalid = 1'b1; if0.ivch = 2'd1; if0.idata = 32'hC000_00C1; if0.iack = 4'b0010;
    tick();
    idle();
    n_checks++; if (u0.g_vc[1].u_ctr.cnt_q !== 4'd3) begin n_fail++; $display("FAIL sa_cnt1: got %0d want 3", u0.g_vc[1].u_ctr.cnt_q); end
    n_checks++;
    if ({if0.ovalid, if0.ovch, if0.odata} !== {1'b1, 2'd1, 32'hC000_00C1}) begin
      n_fail++; $display("FAIL sa_out: got v=%0h ch=%0h d=%0h want v=1 ch=1 d=c00000c1", if0.ovalid, if0.ovch, if0.odata);
    end
    tick();
    n_checks++; if (if0.ovalid !== 1'b0) begin n_fail++; $display("FAIL sa_ovalid_drop: got %0h want 0", if0.ovalid); end
    if0.iack = 4'b0010;
    for (int i = 0; i < 3; i++) tick();
    idle();
    n_checks++; if (u0.g_vc[1].u_ctr.cnt_q !== 4'd0) begin n_fail++; $display("FAIL sa_cnt1_empty: got %0d want 0", u0.g_vc[1].u_ctr.cnt_q); end
    n_checks++; if (if0.oerr !== 3'h0) begin n_fail++; $display("FAIL sa_oerr: got %0h want 0", if0.oerr); end
  endtask

  task automatic test_lock();
    if0.ilck = 4'b1000;
    if0.ivalid = 1'b1; if0.ivch = 2'd3; if0.idata = 32'hD000_00D3;
    tick();
    if0.ivalid = 1'b0; if0.idata = '0; if0.ivch = '0;
    n_checks++; if (if0.olck !== 4'b1000) begin n_fail++; $display("FAIL lock_set: got %0h want 8", if0.olck); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (if0.olck[3] !== 1'b1) begin n_fail++; $display("FAIL lock_hold[%0d]: got %0h want 1", i, if0.olck[3]); end
    end
    if0.ilck = 4'b0000;
    tick();
    n_checks++; if (if0.olck !== 4'b0000) begin n_fail++; $display("FAIL lock_clr: got %0h want 0", if0.olck); end
    if0.iack = 4'b1000;
    tick();
    idle();
    n_checks++; if (if0.ordy !== 4'hF) begin n_fail++; $display("FAIL lock_ordy: got %0h want f", if0.ordy); end
  endtask

  task automatic test_rdy_mode1();
    for (int i = 0; i < 9; i++) begin
      if1.ivalid = 1'b1; if1.ivch = 2'd0; if1.idata = 32'h1000_0000 + 32'(i);
      tick();
      n_checks++;
      if (if1.ordy[0] !== ((i < 7) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL m1_ordy[%0d]: got %0h want %0h", i, if1.ordy[0], (i < 7) ? 1'b1 : 1'b0);
      end
      n_checks++;
      if (if1.oerr !== ((i == 8) ? 3'b001 : 3'b000)) begin
        n_fail++; $display("FAIL m1_oerr_send[%0d]: got %0h want %0h", i, if1.oerr, (i == 8) ? 3'b001 : 3'b000);
      end
    end
    idle();
    n_checks++; if (u1.g_vc[0].u_ctr.cnt_q !== 4'd8) begin n_fail++; $display("FAIL m1_cnt_sat: got %0d want 8", u1.g_vc[0].u_ctr.cnt_q); end
    for (int i = 0; i < 9; i++) begin
      if1.iack = 4'b0001;
      tick();
      n_checks++;
      if (u1.g_vc[0].u_ctr.cnt_q !== ((i < 8) ? 4'(7 - i) : 4'd0)) begin
        n_fail++; $display("FAIL m1_cnt_ack[%0d]: got %0d want %0d", i, u1.g_vc[0].u_ctr.cnt_q, (i < 8) ? 7 - i : 0);
      end
      n_checks++;
      if (if1.oerr !== ((i == 8) ? 3'b011 : 3'b001)) begin
        n_fail++; $display("FAIL m1_oerr_ack[%0d]: got %0h want %0h", i, if1.oerr, (i == 8) ? 3'b011 : 3'b001);
      end
    end
    idle();
    n_checks++; if (if1.ordy !== 4'hF) begin n_fail++; $display("FAIL m1_ordy_end: got %0h want f", if1.ordy); end
  endtask

  task automatic test_illegal_vc();
    if2.ivalid = 1'b1; if2.ivch = 2'd3; if2.idata = 32'hEEEE_EEEE;
    tick();
    if2.ivalid = 1'b0;
    n_checks++; if (if2.ovalid !== 1'b0) begin n_fail++; $display("FAIL ill_ovalid: got %0h want 0", if2.ovalid); end
    n_checks++; if (if2.oerr !== 3'b100) begin n_fail++; $display("FAIL ill_oerr: got %0h want 4", if2.oerr); end
    n_checks++; if (if2.ordy !== 3'h7) begin n_fail++; $display("FAIL ill_ordy: got %0h want 7", if2.ordy); end
    n_checks++;
    if ({u2.g_vc[0].u_ctr.cnt_q, u2.g_vc[1].u_ctr.cnt_q, u2.g_vc[2].u_ctr.cnt_q} !== 12'h0) begin
      n_fail++; $display("FAIL ill_cnt: got %0h/%0h/%0h want 0", u2.g_vc[0].u_ctr.cnt_q, u2.g_vc[1].u_ctr.cnt_q, u2.g_vc[2].u_ctr.cnt_q);
    end
    n_checks++; if (if2.olck !== 3'h0) begin n_fail++; $display("FAIL ill_olck: got %0h want 0", if2.olck); end
    if2.ivalid = 1'b1; if2.ivch = 2'd2; if2.idata = 32'hF000_00F2;
    tick();
    idle();
    n_checks++;
    if ({if2.ovalid, if2.ovch, if2.odata} !== {1'b1, 2'd2, 32'hF000_00F2}) begin
      n_fail++; $display("FAIL ill_legal_out: got v=%0h ch=%0h d=%0h want v=1 ch=2 d=f00000f2", if2.ovalid, if2.ovch, if2.odata);
    end
    n_checks++; if (if2.oerr !== 3'b100) begin n_fail++; $display("FAIL ill_sticky: got %0h want 4", if2.oerr); end
  endtask

  task automatic test_reset_mid();
    if0.ivalid = 1'b1; if0.ivch = 2'd0; if0.idata = 32'h5555_0000;
    tick();
    if0.idata = 32'h5555_0001; if0.ilck = 4'b0001;
    tick();
    #3;
    rst_ = 1'b0;
    #1;
    n_checks++; if ({if0.ovalid, if0.ovch, if0.odata} !== 35'h0) begin n_fail++; $display("FAIL rm_out: got v=%0h ch=%0h d=%0h want 0", if0.ovalid, if0.ovch, if0.odata); end
    n_checks++; if (if0.olck !== 4'h0) begin n_fail++; $display("FAIL rm_olck: got %0h want 0", if0.olck); end
    n_checks++; if (if0.ordy !== 4'hF) begin n_fail++; $display("FAIL rm_ordy: got %0h want f", if0.ordy); end
    n_checks++; if (u0.g_vc[0].u_ctr.cnt_q !== 4'd0) begin n_fail++; $display("FAIL rm_cnt0: got %0d want 0", u0.g_vc[0].u_ctr.cnt_q); end
    n_checks++; if ({if1.oerr, if2.oerr} !== 6'h0) begin n_fail++; $display("FAIL rm_oerr: got %0h/%0h want 0", if1.oerr, if2.oerr); end
    idle();
    @(negedge clk);
    rst_ = 1'b1;
    tick();
    n_checks++; if ({if0.ovalid, if0.ordy, if0.oerr} !== {1'b0, 4'hF, 3'h0}) begin n_fail++; $display("FAIL rm_after: got v=%0h r=%0h e=%0h want v=0 r=f e=0", if0.ovalid, if0.ordy, if0.oerr); end
  endtask

  initial begin
    idle();
    #2;
    test_reset();
    test_fill_vc2();
    test_send_ack_same();
    test_lock();
    test_rdy_mode1();
    test_illegal_vc();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
